// File: rtl/irr_priority_resolver.sv
// 8259 request front end: IR sampling, edge/level IRR, masking and rotatable fully nested priority.
// Define IRR_INPUT_SYNC_EN to insert a two-flop synchronizer ahead of the IR sample register.
module irr_priority_resolver #(
    parameter  int NUM_IR = 8,
    localparam int IDX_W  = $clog2(NUM_IR)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_IR-1:0] ir,
    input  logic              ltim,
    input  logic              init_clear,
    input  logic [NUM_IR-1:0] imr,
    input  logic [NUM_IR-1:0] isr,
    input  logic              ack_set,
    input  logic              rotate_load,
    input  logic [IDX_W-1:0]  rotate_base,
    output logic [NUM_IR-1:0] irr,
    output logic              int_req,
    output logic [IDX_W-1:0]  highest_idx
);

    logic [NUM_IR-1:0] r_ir_s;
    logic [NUM_IR-1:0] r_ir_d;
    logic [NUM_IR-1:0] r_irr;
    logic [IDX_W-1:0]  r_lowest;
    logic              r_int_req;
    logic [IDX_W-1:0]  r_highest_idx;

    logic [NUM_IR-1:0] w_ir_src;
    logic [NUM_IR-1:0] w_cand;
    logic [NUM_IR-1:0] w_ack_mask;
    logic [NUM_IR-1:0] w_irr_nxt;
    logic [IDX_W-1:0]  w_base;
    logic              w_win_found;
    logic [IDX_W-1:0]  w_win_rank;
    logic              w_isr_found;
    logic [IDX_W-1:0]  w_isr_rank;
    logic              w_int_req_nxt;

`ifdef IRR_INPUT_SYNC_EN
    logic [NUM_IR-1:0] r_sync1;
    logic [NUM_IR-1:0] r_sync2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= ir;
            r_sync2 <= r_sync1;
        end
    end

    assign w_ir_src = r_sync2;
`else
    assign w_ir_src = ir;
`endif

    // Ranks are measured from lowest+1, so rank 0 is the highest priority level.
    always_comb begin
        w_cand      = r_irr & ~imr;
        w_base      = r_lowest + IDX_W'(1);
        w_win_found = 1'b0;
        w_win_rank  = '0;
        w_isr_found = 1'b0;
        w_isr_rank  = '0;
        for (int unsigned k = 0; k < NUM_IR; k++) begin
            if (!w_win_found && w_cand[w_base + IDX_W'(k)]) begin
                w_win_found = 1'b1;
                w_win_rank  = IDX_W'(k);
            end
            if (!w_isr_found && isr[w_base + IDX_W'(k)]) begin
                w_isr_found = 1'b1;
                w_isr_rank  = IDX_W'(k);
            end
        end
        w_int_req_nxt = w_win_found && (!w_isr_found || (w_win_rank < w_isr_rank));
    end

    // Edge mode lets a fresh edge beat the ack clear; level mode lets the clear win.
    always_comb begin
        w_ack_mask = '0;
        if (ack_set) begin
            w_ack_mask[r_highest_idx] = 1'b1;
        end
        if (ltim) begin
            w_irr_nxt = r_ir_s & ~w_ack_mask;
        end else begin
            w_irr_nxt = (r_irr & ~w_ack_mask) | (r_ir_s & ~r_ir_d);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ir_s        <= '0;
            r_ir_d        <= '1;
            r_irr         <= '0;
            r_lowest      <= IDX_W'(NUM_IR - 1);
            r_int_req     <= 1'b0;
            r_highest_idx <= '0;
        end else begin
            r_ir_s <= w_ir_src;
            if (init_clear) begin
                r_ir_d    <= '1;
                r_irr     <= '0;
                r_lowest  <= IDX_W'(NUM_IR - 1);
                r_int_req <= 1'b0;
            end else begin
                r_ir_d    <= r_ir_s;
                r_irr     <= w_irr_nxt;
                r_int_req <= w_int_req_nxt;
                if (rotate_load) begin
                    r_lowest <= rotate_base;
                end
                if (w_int_req_nxt) begin
                    r_highest_idx <= w_base + w_win_rank;
                end
            end
        end
    end

    assign irr         = r_irr;
    assign int_req     = r_int_req;
    assign highest_idx = r_highest_idx;

endmodule
